// File: rtl/daisy_duty_pkg.sv
// Shared types and defaults for the daisy-chained duty-cycle scheduler.
package daisy_duty_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ARM,
    MEAS,
    RESULT
  } state_e;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TMO_CYC_DEF = 65535;

endpackage

// File: rtl/daisy_duty_cnt.sv
// Saturating period/high-time counter pair with a sticky overflow flag.
module daisy_duty_cnt
  import daisy_duty_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             high_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             ovf_q, ovf_d;

  // Load starts a fresh measurement; an increment attempted at all-ones sets ovf instead.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    if (load_i) begin
      period_d = CNT_W'(1);
      high_d   = CNT_W'(1);
      ovf_d    = 1'b0;
    end else if (inc_i) begin
      if (period_q == CNT_MAX) ovf_d = 1'b1;
      else                     period_d = period_q + CNT_W'(1);
      if (high_i) begin
        if (high_q == CNT_MAX) ovf_d = 1'b1;
        else                   high_d = high_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/daisy_duty_sched.sv
// Sweeps the enabled channels in index order, measuring period and high time of each.
// Define DAISY_DUTY_TIMEOUT_EN to add an ARM/MEAS watchdog reported on res_tmo.
module daisy_duty_sched
  import daisy_duty_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         sig_i,
  input  logic [NCH-1:0]         chan_en,
  input  logic                   start,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(NCH)-1:0] res_ch,
  output logic [CNT_W-1:0]       res_period,
  output logic [CNT_W-1:0]       res_high,
  output logic                   res_ovf,
  output logic                   res_tmo
);

  localparam int unsigned CH_W = $clog2(NCH);

  if (NCH < 2 || CNT_W < 2 || TMO_CYC < 1) begin : g_cfg_check
    $error("daisy_duty_sched: unsupported parameter set");
  end

  state_e           state_q, state_d;
  logic [NCH-1:0]   sync1_q, sync2_q, prev_q;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [CH_W-1:0]  ch_q, ch_d, pick;
  logic             busy_q;
  logic             val_q, val_d;
  logic [CH_W-1:0]  rch_q, rch_d;
  logic [CNT_W-1:0] rper_q, rper_d, rhigh_q, rhigh_d;
  logic             rovf_q, rovf_d;
  logic             sel_sync, sel_edge, cnt_load, cnt_inc, cnt_ovf;
  logic [CNT_W-1:0] cnt_period, cnt_high;

`ifdef DAISY_DUTY_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] wait_q, wait_d;
  logic             rtmo_q, rtmo_d;
  logic             tmo_hit;
  assign tmo_hit = (wait_q == TMO_W'(TMO_CYC - 1));
  assign res_tmo = rtmo_q;
`else
  assign res_tmo = 1'b0;
`endif

  // Channel mux onto the synchronized value and its one-cycle-old copy.
  assign sel_sync = sync2_q[ch_q];
  assign sel_edge = sync2_q[ch_q] & ~prev_q[ch_q];

  // Lowest-index pending channel; the descending scan lets the lowest hit win.
  always_comb begin
    pick = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) pick = CH_W'(i);
    end
  end

  daisy_duty_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cnt_load),
    .inc_i   (cnt_inc),
    .high_i  (sel_sync),
    .period_o(cnt_period),
    .high_o  (cnt_high),
    .ovf_o   (cnt_ovf)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ch_d     = ch_q;
    val_d    = val_q;
    rch_d    = rch_q;
    rper_d   = rper_q;
    rhigh_d  = rhigh_q;
    rovf_d   = rovf_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
`ifdef DAISY_DUTY_TIMEOUT_EN
    wait_d   = wait_q;
    rtmo_d   = rtmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && (chan_en != '0)) begin
          pend_d  = chan_en;
          state_d = SELECT;
        end
      end
      SELECT: begin
`ifdef DAISY_DUTY_TIMEOUT_EN
        wait_d = '0;
`endif
        if (pend_q != '0) begin
          pend_d[pick] = 1'b0;
          ch_d         = pick;
          state_d      = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (sel_edge) begin
          cnt_load = 1'b1;
          state_d  = MEAS;
`ifdef DAISY_DUTY_TIMEOUT_EN
          wait_d   = '0;
        end else if (tmo_hit) begin
          val_d   = 1'b1;
          rch_d   = ch_q;
          rper_d  = '0;
          rhigh_d = '0;
          rovf_d  = 1'b0;
          rtmo_d  = 1'b1;
          state_d = RESULT;
        end else begin
          wait_d = wait_q + TMO_W'(1);
`endif
        end
      end
      MEAS: begin
        if (sel_edge) begin
          val_d   = 1'b1;
          rch_d   = ch_q;
          rper_d  = cnt_period;
          rhigh_d = cnt_high;
          rovf_d  = cnt_ovf;
          state_d = RESULT;
`ifdef DAISY_DUTY_TIMEOUT_EN
          rtmo_d  = 1'b0;
          wait_d  = '0;
        end else if (tmo_hit) begin
          val_d   = 1'b1;
          rch_d   = ch_q;
          rper_d  = cnt_period;
          rhigh_d = cnt_high;
          rovf_d  = cnt_ovf;
          rtmo_d  = 1'b1;
          state_d = RESULT;
`endif
        end else begin
          cnt_inc = 1'b1;
`ifdef DAISY_DUTY_TIMEOUT_EN
          wait_d  = wait_q + TMO_W'(1);
`endif
        end
      end
      RESULT: begin
        if (res_ready) begin
          val_d   = 1'b0;
          state_d = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      state_q <= IDLE;
      pend_q  <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      val_q   <= 1'b0;
      rch_q   <= '0;
      rper_q  <= '0;
      rhigh_q <= '0;
      rovf_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      pend_q  <= pend_d;
      ch_q    <= ch_d;
      busy_q  <= (state_d != IDLE);
      val_q   <= val_d;
      rch_q   <= rch_d;
      rper_q  <= rper_d;
      rhigh_q <= rhigh_d;
      rovf_q  <= rovf_d;
    end
  end

`ifdef DAISY_DUTY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      rtmo_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      rtmo_q <= rtmo_d;
    end
  end
`endif

  assign busy       = busy_q;
  assign res_valid  = val_q;
  assign res_ch     = rch_q;
  assign res_period = rper_q;
  assign res_high   = rhigh_q;
  assign res_ovf    = rovf_q;

endmodule

// File: tb/tb_daisy_duty_sched.sv
// Self-checking bench for daisy_duty_sched: periodic waveforms with known period/high time.
module tb_daisy_duty_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        res_ready;
  logic [3:0]  sig_i;
  logic [3:0]  chan_en;

  logic        busy, res_valid, res_ovf, res_tmo;
  logic [1:0]  res_ch;
  logic [15:0] res_period, res_high;

  logic        s_busy, s_valid, s_ovf, s_tmo;
  logic [1:0]  s_ch;
  logic [3:0]  s_period, s_high;

  int n_cmp = 0;
  int n_bad = 0;

  int gen_p  [NCH] = '{default: 0};
  int gen_h  [NCH] = '{default: 0};
  int gen_t0 [NCH] = '{default: 0};
  int cyc = 0;

  daisy_duty_sched #(.NCH(NCH), .CNT_W(16), .TMO_CYC(TMO)) u_dut (
    .clk(clk), .rst(rst), .sig_i(sig_i), .chan_en(chan_en), .start(start),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_period(res_period), .res_high(res_high), .res_ovf(res_ovf), .res_tmo(res_tmo)
  );

  daisy_duty_sched #(.NCH(NCH), .CNT_W(4), .TMO_CYC(TMO)) u_dut4 (
    .clk(clk), .rst(rst), .sig_i(sig_i), .chan_en(chan_en), .start(start),
    .busy(s_busy), .res_valid(s_valid), .res_ready(res_ready), .res_ch(s_ch),
    .res_period(s_period), .res_high(s_high), .res_ovf(s_ovf), .res_tmo(s_tmo)
  );

  always #5 clk = ~clk;

  // Waveform source: channel c is high for gen_h cycles of every gen_p; gen_p == 0 means stuck low.
  initial begin
    sig_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        if (gen_p[c] == 0) sig_i[c] = 1'b0;
        else               sig_i[c] = (((cyc - gen_t0[c]) % gen_p[c]) < gen_h[c]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wave(input int c, input int p, input int h);
    gen_p[c]  = p;
    gen_h[c]  = h;
    gen_t0[c] = cyc;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] mask);
    chan_en = mask;
    start   = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits for one result on the main DUT; with junk set, pokes start/chan_en while a sweep runs.
  task automatic get_result(input int budget, input bit junk, output bit ok,
                            output logic [1:0] ch, output logic [15:0] per,
                            output logic [15:0] hi, output logic ovf, output logic tmo);
    ok = 1'b0; ch = '0; per = '0; hi = '0; ovf = 1'b0; tmo = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (res_valid === 1'b1) begin
        ok = 1'b1; ch = res_ch; per = res_period; hi = res_high; ovf = res_ovf; tmo = res_tmo;
        start = 1'b0;
      end else if (junk) begin
        start   = 1'($urandom_range(0, 1));
        chan_en = 4'($urandom);
      end
      step();
    end
    start = 1'b0;
  endtask

  // Model: enabled channels reported in ascending order with their generated period/high.
  task automatic run_sweep(input logic [3:0] mask, input bit junk, input string tag);
    int          exp_q[$];
    bit          ok;
    logic [1:0]  ch;
    logic [15:0] per, hi;
    logic        ovf, tmo;
    for (int c = 0; c < NCH; c++) if (mask[c]) exp_q.push_back(c);
    pulse_start(mask);
    while (exp_q.size() > 0) begin
      int e;
      e = exp_q.pop_front();
      get_result(400, junk, ok, ch, per, hi, ovf, tmo);
      chan_en = mask;
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s_timeout: no result for ch %0d within budget", tag, e);
        break;
      end
      n_cmp++;
      if (ch !== 2'(e) || per !== 16'(gen_p[e]) || hi !== 16'(gen_h[e]) || ovf !== 1'b0 || tmo !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_result: got ch=%0d per=%0d high=%0d ovf=%0b tmo=%0b want ch=%0d per=%0d high=%0d ovf=0 tmo=0",
                 tag, ch, per, hi, ovf, tmo, e, gen_p[e], gen_h[e]);
      end
    end
    begin
      bit extra;
      extra = 1'b0;
      for (int i = 0; i < 8 && busy === 1'b1; i++) begin
        if (res_valid === 1'b1) extra = 1'b1;
        step();
      end
      n_cmp++;
      if (busy !== 1'b0 || extra) begin
        n_bad++;
        $display("FAIL %s_end: got busy=%0b extra_result=%0b want busy=0 extra_result=0", tag, busy, extra);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got busy=%0b valid=%0b want 0 0", busy, res_valid);
    end
    n_cmp++;
    if (res_ch !== 2'd0 || res_period !== 16'd0 || res_high !== 16'd0) begin
      n_bad++; $display("FAIL reset_data: got ch=%0d per=%0d high=%0d want 0 0 0", res_ch, res_period, res_high);
    end
    n_cmp++;
    if (res_ovf !== 1'b0 || res_tmo !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got ovf=%0b tmo=%0b want 0 0", res_ovf, res_tmo);
    end
  endtask

  task automatic test_single();
    set_wave(0, 8, 3);
    repeat (4) step();
    run_sweep(4'b0001, 1'b0, "single");
  endtask

  task automatic test_two_chan();
    set_wave(1, 10, 5);
    set_wave(3, 4, 1);
    repeat (4) step();
    run_sweep(4'b1010, 1'b0, "two_chan");
  endtask

  task automatic test_zero_mask();
    pulse_start(4'b0000);
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_mask: got busy=%0b valid=%0b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NCH; c++) begin
        int p;
        p = int'($urandom_range(2, 30));
        set_wave(c, p, int'($urandom_range(1, p - 1)));
      end
      repeat (4) step();
      run_sweep(4'($urandom_range(1, 15)), 1'b1, "random");
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    logic [1:0]  ch;
    logic [15:0] per, hi;
    logic        ovf, tmo;
    set_wave(0, 6, 2);
    set_wave(2, 7, 4);
    repeat (4) step();
    res_ready = 1'b0;
    pulse_start(4'b0101);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (res_valid === 1'b1) ok = 1'b1;
      else step();
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL stall_timeout: no result within budget");
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || res_ch !== 2'd0 || res_period !== 16'd6 || res_high !== 16'd2) begin
        n_bad++;
        $display("FAIL stall_hold: cycle %0d got valid=%0b busy=%0b ch=%0d per=%0d high=%0d want 1 1 0 6 2",
                 i, res_valid, busy, res_ch, res_period, res_high);
      end
      step();
    end
    res_ready = 1'b1;
    get_result(5, 1'b0, ok, ch, per, hi, ovf, tmo);
    n_cmp++;
    if (!ok || ch !== 2'd0 || per !== 16'd6 || hi !== 16'd2) begin
      n_bad++; $display("FAIL stall_accept: got ok=%0b ch=%0d per=%0d high=%0d want 1 0 6 2", ok, ch, per, hi);
    end
    get_result(200, 1'b0, ok, ch, per, hi, ovf, tmo);
    n_cmp++;
    if (!ok || ch !== 2'd2 || per !== 16'd7 || hi !== 16'd4 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL stall_next: got ok=%0b ch=%0d per=%0d high=%0d ovf=%0b want 1 2 7 4 0", ok, ch, per, hi, ovf);
    end
    repeat (4) step();
  endtask

  // Narrow-counter instance: saturation at 15 and the exact-fit boundary.
  task automatic test_ovf();
    int tp[3] = '{40, 15, 16};
    int th[3] = '{20, 14, 3};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bit          ok;
      logic [3:0]  ep, eh;
      logic        eo;
      ep = (tp[k] > 15) ? 4'd15 : 4'(tp[k]);
      eh = (th[k] > 15) ? 4'd15 : 4'(th[k]);
      eo = (tp[k] > 15) || (th[k] > 15);
      set_wave(0, tp[k], th[k]);
      repeat (4) step();
      pulse_start(4'b0001);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
        if (s_valid === 1'b1) ok = 1'b1;
        else step();
      end
      n_cmp++;
      if (!ok || s_ch !== 2'd0 || s_period !== ep || s_high !== eh || s_ovf !== eo) begin
        n_bad++;
        $display("FAIL ovf_%0d: got ok=%0b ch=%0d per=%0d high=%0d ovf=%0b want 1 0 %0d %0d %0b",
                 tp[k], ok, s_ch, s_period, s_high, s_ovf, ep, eh, eo);
      end
      for (int i = 0; i < 100 && (s_busy === 1'b1 || busy === 1'b1); i++) step();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_wave(2, 0, 0);
    repeat (4) step();
    pulse_start(4'b0100);
`ifdef DAISY_DUTY_TIMEOUT_EN
    begin
      bit ok;
      int cyc_seen;
      ok = 1'b0;
      cyc_seen = 0;
      for (int i = 1; i <= 110 && !ok; i++) begin
        if (res_valid === 1'b1) begin
          ok = 1'b1;
          cyc_seen = i;
        end else step();
      end
      n_cmp++;
      if (!ok || cyc_seen > 103) begin
        n_bad++; $display("FAIL tmo_latency: got ok=%0b cycles=%0d want result within 103", ok, cyc_seen);
      end
      n_cmp++;
      if (res_tmo !== 1'b1 || res_ch !== 2'd2 || res_period !== 16'd0 || res_high !== 16'd0) begin
        n_bad++; $display("FAIL tmo_result: got tmo=%0b ch=%0d per=%0d high=%0d want 1 2 0 0",
                          res_tmo, res_ch, res_period, res_high);
      end
      repeat (4) step();
    end
`else
    repeat (150) step();
    n_cmp++;
    if (busy !== 1'b1 || res_valid !== 1'b0 || res_tmo !== 1'b0) begin
      n_bad++; $display("FAIL no_tmo_wait: got busy=%0b valid=%0b tmo=%0b want 1 0 0", busy, res_valid, res_tmo);
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit stale;
    set_wave(0, 30, 12);
    repeat (4) step();
    pulse_start(4'b0001);
    repeat (40) step();
    n_cmp++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_pre: got busy=%0b valid=%0b want 1 0", busy, res_valid);
    end
    do_reset();
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
      step();
    end
    n_cmp++;
    if (stale) begin
      n_bad++; $display("FAIL rst_mid_stale: got activity_after_reset=1 want 0");
    end
    run_sweep(4'b0001, 1'b0, "rst_mid_fresh");
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b1;
    chan_en   = '0;
    test_reset();
    test_single();
    test_two_chan();
    test_zero_mask();
    test_random();
    test_backpressure();
    test_ovf();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
